// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch sequencer: state encoding, redirect kinds, pending record.
// Pure declarations; no latency or backpressure of its own.
// Redirect kinds are numbered so a larger value means higher priority.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fseq_state_t;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_J    = 2'd1,
        R_JR   = 2'd2,
        R_BRA  = 2'd3
    } redir_kind_t;

    typedef struct packed {
        logic        valid;
        redir_kind_t kind;
        word_t       addr;
    } redir_t;

endpackage

// File: rtl/fetch_sequencer_redirect_latch.sv
// Pending-redirect register with priority merge of live bra/jr/j requests.
// Apply is combinational (0 cycles); storage updates on posedge clk.
// A redirect seen while adv=0 is held until fetch advances, then applied and cleared.
module redirect_latch
    import cpu_types_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        active,
    input  logic        adv,
    input  logic        discard,
    input  logic        ex_bra,
    input  logic [31:0] ex_bra_addr,
    input  logic        ex_jr,
    input  logic [31:0] ex_jr_addr,
    input  logic        id_j,
    input  logic [25:0] id_j_addr,
    output logic [1:0]  eff_kind,
    output logic        bra_enable,
    output logic [31:0] bra_addr,
    output logic        jr_enable,
    output logic [31:0] jr_addr,
    output logic        j_enable,
    output logic [25:0] j_addr
);

    redir_t      pend, pend_nxt;
    redir_kind_t live_kind, kind;
    word_t       live_addr, addr;

    always_comb begin
        live_kind = R_NONE;
        live_addr = '0;
        if (ex_bra) begin
            live_kind = R_BRA;
            live_addr = ex_bra_addr;
        end else if (ex_jr) begin
            live_kind = R_JR;
            live_addr = ex_jr_addr;
        end else if (id_j) begin
            live_kind = R_J;
            live_addr = {6'd0, id_j_addr};
        end

        // Pending wins unless the live request strictly outranks it.
        if (pend.valid && (pend.kind >= live_kind)) begin
            kind = pend.kind;
            addr = pend.addr;
        end else begin
            kind = live_kind;
            addr = live_addr;
        end
        if (!active) begin
            kind = R_NONE;
            addr = '0;
        end

        pend_nxt = pend;
        if (!active || discard)
            pend_nxt = '0;
        else if (kind != R_NONE)
            pend_nxt = adv ? redir_t'('0) : '{valid: 1'b1, kind: kind, addr: addr};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    assign eff_kind   = kind;
    assign bra_enable = adv && (kind == R_BRA);
    assign jr_enable  = adv && (kind == R_JR);
    assign j_enable   = adv && (kind == R_J);
    assign bra_addr   = (kind == R_BRA) ? addr : '0;
    assign jr_addr    = (kind == R_JR)  ? addr : '0;
    assign j_addr     = (kind == R_J)   ? addr[25:0] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC advance/hold/redirect, pipeline flush/stall, halt, stall counter.
// Controls are combinational from state, pending redirect and inputs; state updates next edge.
// I-miss, D-stall or load-use hold the PC; redirects arriving during a hold are latched.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             lu_hazard,
    input  logic             ex_bra,
    input  logic [31:0]      ex_bra_addr,
    input  logic             ex_jr,
    input  logic [31:0]      ex_jr_addr,
    input  logic             id_j,
    input  logic [25:0]      id_j_addr,
    input  logic             wb_halt,
    output logic             pc_enable,
    output logic             bra_enable,
    output logic [31:0]      bra_addr,
    output logic             jr_enable,
    output logic [31:0]      jr_addr,
    output logic             j_enable,
    output logic [25:0]      j_addr,
    output logic             imemREN,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    fseq_state_t state, state_nxt;
    logic        run, dstall, adv;
    logic [1:0]  eff_kind;

    assign run    = (state == RUN);
    assign dstall = dmem_req && !dhit;
    assign adv    = run && ihit && !dstall && !lu_hazard;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (wb_halt) state_nxt = HALTED;
            default: state_nxt = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    redirect_latch u_redirect_latch (
        .clk         (clk),
        .n_rst       (n_rst),
        .active      (run),
        .adv         (adv),
        .discard     (wb_halt),
        .ex_bra      (ex_bra),
        .ex_bra_addr (ex_bra_addr),
        .ex_jr       (ex_jr),
        .ex_jr_addr  (ex_jr_addr),
        .id_j        (id_j),
        .id_j_addr   (id_j_addr),
        .eff_kind    (eff_kind),
        .bra_enable  (bra_enable),
        .bra_addr    (bra_addr),
        .jr_enable   (jr_enable),
        .jr_addr     (jr_addr),
        .j_enable    (j_enable),
        .j_addr      (j_addr)
    );

    assign pc_enable  = adv;
    assign imemREN    = run;
    assign stall_ifid = run && !adv;
    assign flush_ifid = adv && (eff_kind != R_NONE);
    // bra/jr resolve in EX, so the ID/EX occupant is wrong-path too; j only squashes IF/ID.
    assign flush_idex = (adv && ((eff_kind == R_BRA) || (eff_kind == R_JR)))
                     || (run && lu_hazard && !dstall);
    assign halt       = (state == HALTED);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            stall_cnt <= '0;
        else if (run && !adv && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
